// File: rtl/pc_next_ctrl_pkg.sv
// Shared definitions for the next-PC controller: target-select codes,
// controller state encoding and the sequential PC increment.
package pc_ctrl_pkg;

  // Target select codes driven by the decoder
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_REG = 2'b01;
  localparam logic [1:0] PCSEL_BR  = 2'b10;
  localparam logic [1:0] PCSEL_JMP = 2'b11;

  // Controller state encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_FETCH = 1'b0;
  localparam state_t ST_FLUSH = 1'b1;

  // Byte distance between consecutive instructions
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_next_ctrl_if.sv
// Decode-result and fetch-PC bundle between decoder, next-PC controller and
// fetch. The master modport is the controller; slave is its environment.
interface pc_next_ctrl_if #(
  parameter int PC_W = 32
);

  logic            dec_valid;
  logic            dec_ready;
  logic [1:0]      sel;
  logic            B;
  logic [PC_W-1:0] dec_pc;
  logic [15:0]     imm;
  logic [25:0]     jidx;
  logic [PC_W-1:0] rs_val;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic            misalign;

  modport master (
    input  dec_valid, sel, B, dec_pc, imm, jidx, rs_val, pc_ready,
    output dec_ready, pc, pc_valid, flush, misalign
  );

  modport slave (
    output dec_valid, sel, B, dec_pc, imm, jidx, rs_val, pc_ready,
    input  dec_ready, pc, pc_valid, flush, misalign
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect target calculation from the decoder's select code.
// The jump form keeps the top PC_W-28 bits of dec_pc, so PC_W must exceed 28.
module pc_target_calc
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] dec_pc,
  input  logic [15:0]     imm,
  input  logic [25:0]     jidx,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] target,
  output logic            misalign
);

  logic        [PC_W-1:0] seq_pc;
  logic signed [PC_W-1:0] br_off;

  assign seq_pc   = dec_pc + PC_W'(PC_INC);
  assign br_off   = {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign misalign = (sel == PCSEL_REG) && (rs_val[1:0] != 2'b00);

  // Select the redirect target; all sums wrap modulo 2^PC_W
  always_comb begin
    target = seq_pc;
    case (sel)
      PCSEL_SEQ: target = seq_pc;
      PCSEL_REG: target = {rs_val[PC_W-1:2], 2'b00};
      PCSEL_BR:  target = seq_pc + $unsigned(br_off);
      PCSEL_JMP: target = {dec_pc[PC_W-1:28], jidx, 2'b00};
      default:   target = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: holds the fetch PC, advances it on fetch handshakes and
// applies decoder redirects, which flush in-flight fetches and open a fixed
// bubble window before fetch resumes.
module pc_next_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  pc_next_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] target;
  logic            tgt_misalign;
  logic            active;
  logic            redirect;
  logic            advance;

  pc_target_calc #(
    .PC_W (PC_W)
  ) u_target (
    .sel      (bus.sel),
    .dec_pc   (bus.dec_pc),
    .imm      (bus.imm),
    .jidx     (bus.jidx),
    .rs_val   (bus.rs_val),
    .target   (target),
    .misalign (tgt_misalign)
  );

  // Fetch is offered only outside reset and outside the bubble window. Only a
  // B of exactly 1 redirects, so an unknown B from the decoder's default case
  // falls through to a sequential advance.
  assign active   = !rst && (state == ST_FETCH);
  assign redirect = active && bus.dec_valid && (bus.B === 1'b1);
  assign advance  = active && bus.pc_ready;

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = active;
  assign bus.dec_ready = active;
  assign bus.flush     = redirect;
  assign bus.misalign  = redirect && tgt_misalign;

  // State, bubble counter and PC register; a redirect takes priority over a
  // simultaneous fetch handshake, so no +4 is applied on that edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      cnt   <= '0;
      pc_q  <= RESET_PC;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect) begin
            pc_q  <= target;
            state <= ST_FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES);
          end else if (advance) begin
            pc_q <= pc_q + PC_W'(PC_INC);
          end
        end
        default: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_FETCH;
          end
        end
      endcase
    end
  end

endmodule
